// File: rtl/seq_restoring_div.sv
// seq_restoring_div: multi-cycle unsigned restoring divider.
// One quotient bit per clock through a single shared WIDTH+1-bit subtractor,
// driven by a start/busy/done handshake.
// Optional feature macro: SEQ_RESTORING_DIV_DZ_CHECK_EN
//   defined   -> divisor==0 bypasses RUN, completes in 2 cycles and raises dz
//   undefined -> divisor==0 runs the normal iteration, dz is tied 0
module seq_restoring_div #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    localparam int unsigned    CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;        // dividend shift register, fills with quotient bits
    logic [WIDTH-1:0] d_q, d_d;        // latched divisor
    // The partial remainder is always < divisor between iterations, so the top
    // bit of the WIDTH+1-bit remainder is never set and only WIDTH bits are kept.
    logic [WIDTH-1:0] r_q, r_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   trial_shift;
    logic [WIDTH:0]   trial_diff;
    logic             borrow;

    // Shared subtractor: shifted partial remainder minus zero-extended divisor.
    always_comb begin
        trial_shift = {r_q, q_q[WIDTH-1]};
        trial_diff  = trial_shift - {1'b0, d_q};
        borrow      = trial_diff[WIDTH];
    end

`ifdef SEQ_RESTORING_DIV_DZ_CHECK_EN
    logic dz_q, dz_d;
`endif

    // Next-state logic for the control FSM, datapath and result registers.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef SEQ_RESTORING_DIV_DZ_CHECK_EN
        dz_d    = dz_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = StRun;
`ifdef SEQ_RESTORING_DIV_DZ_CHECK_EN
                    // Zero divisor: publish the natural algorithm result at once.
                    if (divisor == '0) begin
                        state_d = StDone;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                    end
`endif
                end
            end

            StRun: begin
                if (borrow) begin
                    // Trial subtraction went negative: restore.
                    r_d = trial_shift[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end else begin
                    r_d = trial_diff[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    // Last iteration: capture results as DONE is entered.
                    state_d = StDone;
                    quot_d  = q_d;
                    rem_d   = r_d;
`ifdef SEQ_RESTORING_DIV_DZ_CHECK_EN
                    dz_d    = 1'b0;
`endif
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // State and registered outputs; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SEQ_RESTORING_DIV_DZ_CHECK_EN
    // Divide-by-zero flag, updated only when a result is published.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz_d;
        end
    end

    assign dz = dz_q;
`else
    assign dz = 1'b0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule
